// File: rtl/ib_issue_pkg.sv
// Shared types and opcode helpers for the instruction-buffer issue stage.
package ib_issue_pkg;

  typedef enum logic [0:0] {
    RUN         = 1'b0,
    WAIT_SERIAL = 1'b1
  } issue_state_t;

  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  function automatic logic is_serial(input logic [6:0] opcode);
    return (opcode == OPC_SYSTEM) || (opcode == OPC_MISC_MEM);
  endfunction

endpackage

// File: rtl/ib_issue_count.sv
// Combinational issue-count generator: how many buffer heads to pop this cycle,
// and the matching thermometer read enable.
module ib_issue_count
  import ib_issue_pkg::*;
#(
  parameter int Depth       = 32,
  parameter int Fetch_NUM   = 4,
  parameter int ISSUE_WIDTH = 4,
  localparam int CNT_W      = $clog2(Depth),
  localparam int N_W        = $clog2(ISSUE_WIDTH + 1)
) (
  input  logic [CNT_W-1:0]                  inst_count,
  input  logic [ISSUE_WIDTH-1:0][6:0]       slot_opc,
  input  logic                              ld,
  output logic [N_W-1:0]                    n,
  output logic [Fetch_NUM-1:0]              inst_ren
);

  int avail;
  int cnt;

  always_comb begin
    avail    = (int'(inst_count) < ISSUE_WIDTH) ? int'(inst_count) : ISSUE_WIDTH;
    cnt      = avail;
    // Scan from the top so the oldest serializing slot wins; a serializing
    // head still issues, but alone.
    for (int k = ISSUE_WIDTH - 1; k >= 0; k--) begin
      if (k < avail && is_serial(slot_opc[k])) cnt = (k == 0) ? 1 : k;
    end
    inst_ren = '0;
    for (int k = 0; k < Fetch_NUM; k++) begin
      inst_ren[k] = ld && (k < cnt);
    end
    n = N_W'(cnt);
  end

endmodule

// File: rtl/ib_issue_stage.sv
// Instruction-buffer read-side controller: pops up to ISSUE_WIDTH heads into a
// registered decode packet. Optional counters: define IB_ISSUE_PERF_EN.
module ib_issue_stage
  import ib_issue_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int Depth       = 32,
  parameter int Fetch_NUM   = 4,
  parameter int ISSUE_WIDTH = 4,
  localparam int CNT_W      = $clog2(Depth),
  localparam int N_W        = $clog2(ISSUE_WIDTH + 1)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   clr,
  input  logic [CNT_W-1:0]                       inst_count,
  input  logic [Fetch_NUM-1:0][DATA_WIDTH-1:0]   buf_inst_i,
  input  logic [Fetch_NUM-1:0][ADDR_WIDTH-1:0]   buf_pc_i,
  input  logic [Fetch_NUM-1:0]                   buf_pred_i,
  output logic [Fetch_NUM-1:0]                   inst_ren,
  output logic [ISSUE_WIDTH-1:0]                 dec_valid,
  output logic [ISSUE_WIDTH-1:0][DATA_WIDTH-1:0] dec_inst,
  output logic [ISSUE_WIDTH-1:0][ADDR_WIDTH-1:0] dec_pc,
  output logic [ISSUE_WIDTH-1:0]                 dec_pred,
  input  logic                                   dec_ready,
  input  logic                                   serial_done
`ifdef IB_ISSUE_PERF_EN
  ,
  output logic [31:0]                            perf_issued,
  output logic [31:0]                            perf_empty_stall,
  output logic [31:0]                            perf_serial_stall
`endif
);

  issue_state_t                   state;
  logic                           pkt_busy;
  logic                           ld;
  logic                           serial_head;
  logic [N_W-1:0]                 n;
  logic [ISSUE_WIDTH-1:0]         valid_mask;
  logic [ISSUE_WIDTH-1:0][6:0]    slot_opc;

  assign pkt_busy    = |dec_valid;
  // rst_n gates the load so no pop can escape while reset is held.
  assign ld          = rst_n & ~clr & (state == RUN) & (~pkt_busy | dec_ready);
  assign serial_head = is_serial(buf_inst_i[0][6:0]);

  always_comb begin
    slot_opc   = '0;
    valid_mask = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      slot_opc[k]   = buf_inst_i[k][6:0];
      valid_mask[k] = (k < int'(n));
    end
  end

  ib_issue_count #(
    .Depth       (Depth),
    .Fetch_NUM   (Fetch_NUM),
    .ISSUE_WIDTH (ISSUE_WIDTH)
  ) u_count (
    .inst_count (inst_count),
    .slot_opc   (slot_opc),
    .ld         (ld),
    .n          (n),
    .inst_ren   (inst_ren)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      dec_valid <= '0;
      dec_inst  <= '0;
      dec_pc    <= '0;
      dec_pred  <= '0;
    end else if (clr) begin
      state     <= RUN;
      dec_valid <= '0;
    end else begin
      if (ld) begin
        dec_valid <= valid_mask;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
          dec_inst[k] <= buf_inst_i[k];
          dec_pc[k]   <= buf_pc_i[k];
          dec_pred[k] <= buf_pred_i[k];
        end
      end else if (dec_ready) begin
        dec_valid <= '0;
      end

      case (state)
        RUN:         if (ld && serial_head && n == N_W'(1)) state <= WAIT_SERIAL;
        WAIT_SERIAL: if (serial_done) state <= RUN;
        default:     state <= RUN;
      endcase
    end
  end

`ifdef IB_ISSUE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued       <= '0;
      perf_empty_stall  <= '0;
      perf_serial_stall <= '0;
    end else begin
      if (ld) perf_issued <= perf_issued + 32'(n);
      if (state == RUN && !pkt_busy && inst_count == '0)
        perf_empty_stall <= perf_empty_stall + 32'd1;
      if (state == WAIT_SERIAL) perf_serial_stall <= perf_serial_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ib_issue_stage.sv
// Self-checking bench for ib_issue_stage: directed scenarios plus a randomized
// run against a queue-based buffer model.
module tb_ib_issue_stage;

  localparam int IW = 4;
  localparam logic [31:0] ADDI  = 32'h00100093;
  localparam logic [31:0] CSRRW = 32'h34011073;

  logic              clk;
  logic              rst_n;
  logic              clr;
  logic [4:0]        inst_count;
  logic [3:0][31:0]  buf_inst;
  logic [3:0][31:0]  buf_pc;
  logic [3:0]        buf_pred;
  logic [3:0]        inst_ren;
  logic [3:0]        dec_valid;
  logic [3:0][31:0]  dec_inst;
  logic [3:0][31:0]  dec_pc;
  logic [3:0]        dec_pred;
  logic              dec_ready;
  logic              serial_done;
`ifdef IB_ISSUE_PERF_EN
  logic [31:0]       perf_issued;
  logic [31:0]       perf_empty_stall;
  logic [31:0]       perf_serial_stall;
`endif

  int total = 0;
  int bad   = 0;

  ib_issue_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .inst_count  (inst_count),
    .buf_inst_i  (buf_inst),
    .buf_pc_i    (buf_pc),
    .buf_pred_i  (buf_pred),
    .inst_ren    (inst_ren),
    .dec_valid   (dec_valid),
    .dec_inst    (dec_inst),
    .dec_pc      (dec_pc),
    .dec_pred    (dec_pred),
    .dec_ready   (dec_ready),
    .serial_done (serial_done)
`ifdef IB_ISSUE_PERF_EN
    ,
    .perf_issued       (perf_issued),
    .perf_empty_stall  (perf_empty_stall),
    .perf_serial_stall (perf_serial_stall)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic bit ser(input logic [31:0] inst);
    return inst[6:0] == 7'b1110011 || inst[6:0] == 7'b0001111;
  endfunction

  // Pop count from the rules: nothing if empty, a serializing head goes alone,
  // otherwise the run of non-serializing heads up to the available limit.
  function automatic int exp_n(input int cnt, input logic [3:0][31:0] h);
    int lim;
    lim = (cnt < IW) ? cnt : IW;
    if (lim == 0) return 0;
    if (ser(h[0])) return 1;
    for (int k = 0; k < lim; k++) if (ser(h[k])) return k;
    return lim;
  endfunction

  task automatic set_heads(input logic [31:0] base, input logic [31:0] i0, input logic [31:0] i1,
                           input logic [31:0] i2, input logic [31:0] i3);
    buf_inst = {i3, i2, i1, i0};
    for (int k = 0; k < 4; k++) buf_pc[k] = base + 32'(4 * k);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; dec_ready = 1'b1; serial_done = 1'b0;
    inst_count = 5'd6; buf_pred = 4'b1111;
    set_heads(32'h80000000, ADDI, ADDI, ADDI, ADDI);
    @(negedge clk); @(negedge clk);
    total++; if (inst_ren !== 4'b0) begin bad++; $display("FAIL reset_ren: got %b exp 0000", inst_ren); end
    total++; if (dec_valid !== 4'b0) begin bad++; $display("FAIL reset_valid: got %b exp 0000", dec_valid); end
    total++; if (dec_pc !== '0) begin bad++; $display("FAIL reset_pc: got %h exp 0", dec_pc); end
    total++; if (dec_inst !== '0 || dec_pred !== 4'b0) begin bad++; $display("FAIL reset_data: got %h/%b exp 0", dec_inst, dec_pred); end
    inst_count = 5'd0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_issue();
    inst_count = 5'd6; buf_pred = 4'b0101; dec_ready = 1'b1;
    set_heads(32'h80000000, ADDI, ADDI, ADDI, ADDI);
    #4;
    total++; if (inst_ren !== 4'b1111) begin bad++; $display("FAIL full_ren: got %b exp 1111", inst_ren); end
    tick();
    inst_count = 5'd0;
    total++; if (dec_valid !== 4'b1111) begin bad++; $display("FAIL full_valid: got %b exp 1111", dec_valid); end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (dec_pc[k] !== 32'h80000000 + 32'(4 * k)) begin
        bad++; $display("FAIL full_pc%0d: got %h exp %h", k, dec_pc[k], 32'h80000000 + 32'(4 * k));
      end
    end
    total++; if (dec_pred !== 4'b0101) begin bad++; $display("FAIL full_pred: got %b exp 0101", dec_pred); end
  endtask

  task automatic test_partial_drain();
    inst_count = 5'd2; dec_ready = 1'b1;
    set_heads(32'h100, ADDI, ADDI, ADDI, ADDI);
    #4;
    total++; if (inst_ren !== 4'b0011) begin bad++; $display("FAIL part_ren: got %b exp 0011", inst_ren); end
    tick();
    total++; if (dec_valid !== 4'b0011) begin bad++; $display("FAIL part_valid: got %b exp 0011", dec_valid); end
    total++; if (dec_pc[1] !== 32'h104) begin bad++; $display("FAIL part_pc1: got %h exp 00000104", dec_pc[1]); end
    inst_count = 5'd0;
    #4;
    total++; if (inst_ren !== 4'b0) begin bad++; $display("FAIL empty_ren: got %b exp 0000", inst_ren); end
    tick();
    total++; if (dec_valid !== 4'b0) begin bad++; $display("FAIL drain_valid: got %b exp 0000", dec_valid); end
  endtask

  task automatic test_serial();
    inst_count = 5'd4; dec_ready = 1'b1;
    set_heads(32'h200, ADDI, ADDI, CSRRW, ADDI);
    #4;
    total++; if (inst_ren !== 4'b0011) begin bad++; $display("FAIL ser_pre_ren: got %b exp 0011", inst_ren); end
    tick();
    set_heads(32'h208, CSRRW, ADDI, ADDI, ADDI);
    #4;
    total++; if (inst_ren !== 4'b0001) begin bad++; $display("FAIL ser_head_ren: got %b exp 0001", inst_ren); end
    tick();
    total++; if (dec_valid !== 4'b0001 || dec_inst[0] !== CSRRW) begin
      bad++; $display("FAIL ser_pkt: got %b/%h exp 0001/%h", dec_valid, dec_inst[0], CSRRW);
    end
    set_heads(32'h20c, ADDI, ADDI, ADDI, ADDI);
    for (int c = 0; c < 5; c++) begin
      #4;
      total++; if (inst_ren !== 4'b0) begin bad++; $display("FAIL ser_wait_ren%0d: got %b exp 0000", c, inst_ren); end
      tick();
    end
    serial_done = 1'b1;
    #4;
    total++; if (inst_ren !== 4'b0) begin bad++; $display("FAIL ser_done_ren: got %b exp 0000", inst_ren); end
    tick();
    serial_done = 1'b0;
    #4;
    total++; if (inst_ren !== 4'b1111) begin bad++; $display("FAIL ser_resume_ren: got %b exp 1111", inst_ren); end
    tick();
    inst_count = 5'd0;
  endtask

  task automatic test_hold();
    dec_ready = 1'b1; inst_count = 5'd0;
    tick(); tick();
    inst_count = 5'd3;
    set_heads(32'h300, ADDI, ADDI, ADDI, ADDI);
    tick();
    dec_ready = 1'b0; inst_count = 5'd4;
    set_heads(32'h400, ADDI, ADDI, ADDI, ADDI);
    for (int c = 0; c < 3; c++) begin
      #4;
      total++; if (inst_ren !== 4'b0) begin bad++; $display("FAIL hold_ren%0d: got %b exp 0000", c, inst_ren); end
      tick();
      total++; if (dec_valid !== 4'b0111 || dec_pc[0] !== 32'h300) begin
        bad++; $display("FAIL hold_pkt%0d: got %b/%h exp 0111/00000300", c, dec_valid, dec_pc[0]);
      end
    end
    dec_ready = 1'b1;
    #4;
    total++; if (inst_ren !== 4'b1111) begin bad++; $display("FAIL b2b_ren: got %b exp 1111", inst_ren); end
    tick();
    total++; if (dec_valid !== 4'b1111 || dec_pc[0] !== 32'h400) begin
      bad++; $display("FAIL b2b_pkt: got %b/%h exp 1111/00000400", dec_valid, dec_pc[0]);
    end
    inst_count = 5'd0;
  endtask

  task automatic test_flush();
    inst_count = 5'd1; dec_ready = 1'b1;
    set_heads(32'h500, CSRRW, ADDI, ADDI, ADDI);
    tick();
    dec_ready = 1'b0; inst_count = 5'd4;
    set_heads(32'h504, ADDI, ADDI, ADDI, ADDI);
    tick();
    clr = 1'b1; serial_done = 1'b1;
    #4;
    total++; if (inst_ren !== 4'b0) begin bad++; $display("FAIL clr_ren: got %b exp 0000", inst_ren); end
    tick();
    clr = 1'b0; serial_done = 1'b0;
    total++; if (dec_valid !== 4'b0) begin bad++; $display("FAIL clr_valid: got %b exp 0000", dec_valid); end
    #4;
    total++; if (inst_ren !== 4'b1111) begin bad++; $display("FAIL clr_run_ren: got %b exp 1111", inst_ren); end
    tick();
  endtask

  task automatic test_async_reset();
    inst_count = 5'd0; dec_ready = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (dec_valid !== 4'b0 || inst_ren !== 4'b0) begin
      bad++; $display("FAIL areset: got valid=%b ren=%b exp 0000/0000", dec_valid, inst_ren);
    end
`ifdef IB_ISSUE_PERF_EN
    total++; if (perf_issued !== 0 || perf_empty_stall !== 0 || perf_serial_stall !== 0) begin
      bad++; $display("FAIL areset_perf: got %0d/%0d/%0d exp 0/0/0", perf_issued, perf_empty_stall, perf_serial_stall);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random(input int cycles);
    logic [31:0] q_inst[$];
    logic [31:0] q_pc[$];
    logic        q_pred[$];
    logic [31:0] next_pc;
    logic [3:0]  m_valid;
    logic [3:0][31:0] m_inst, m_pc;
    logic [3:0]  m_pred;
    bit          m_wait, was_wait, ld;
    int          n, cnt, r;
    logic [3:0]  exp_ren;
    logic [31:0] tmp;
    logic [6:0]  opc;
    int unsigned m_issued, m_empty, m_serial;

    next_pc = 32'h1000; m_valid = '0; m_wait = 0; m_inst = '0; m_pc = '0; m_pred = '0;
    @(negedge clk);
    rst_n = 1'b0; clr = 1'b0; dec_ready = 1'b0; serial_done = 1'b0; inst_count = 5'd0;
    #1 rst_n = 1'b1;
    tick();
    m_issued = 0; m_empty = 1; m_serial = 0;

    for (int c = 0; c < cycles; c++) begin
      if (q_inst.size() < 36) begin
        r = $urandom_range(0, 3);
        for (int i = 0; i < r; i++) begin
          tmp = $urandom();
          case ($urandom_range(0, 9))
            0: opc = 7'b1110011;
            1: opc = 7'b0001111;
            2: opc = 7'b0110011;
            default: opc = 7'b0010011;
          endcase
          q_inst.push_back({tmp[31:7], opc});
          q_pc.push_back(next_pc);
          q_pred.push_back(tmp[0]);
          next_pc += 4;
        end
      end
      clr         = ($urandom_range(0, 29) == 0);
      dec_ready   = ($urandom_range(0, 3) != 0);
      serial_done = m_wait ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
      cnt         = (q_inst.size() < 31) ? q_inst.size() : 31;
      inst_count  = 5'(cnt);
      for (int k = 0; k < 4; k++) begin
        buf_inst[k] = (k < q_inst.size()) ? q_inst[k] : $urandom();
        buf_pc[k]   = (k < q_pc.size()) ? q_pc[k] : $urandom();
        buf_pred[k] = (k < q_pred.size()) ? q_pred[k] : 1'b0;
      end

      ld      = !clr && !m_wait && (m_valid == 4'b0 || dec_ready);
      n       = exp_n(cnt, buf_inst);
      exp_ren = ld ? 4'((1 << n) - 1) : 4'b0;
      #4;
      total++; if (inst_ren !== exp_ren) begin bad++; $display("FAIL rnd_ren c=%0d: got %b exp %b", c, inst_ren, exp_ren); end

      @(posedge clk);
      if (ld) m_issued += n;
      if (!m_wait && m_valid == 4'b0 && cnt == 0) m_empty++;
      if (m_wait) m_serial++;
      was_wait = m_wait;
      if (clr) begin
        m_valid = '0; m_wait = 0;
        q_inst.delete(); q_pc.delete(); q_pred.delete();
      end else begin
        if (ld) begin
          m_valid = 4'((1 << n) - 1);
          m_inst = buf_inst; m_pc = buf_pc; m_pred = buf_pred;
          if (n == 1 && ser(buf_inst[0])) m_wait = 1;
          for (int i = 0; i < n; i++) begin
            void'(q_inst.pop_front()); void'(q_pc.pop_front()); void'(q_pred.pop_front());
          end
        end else if (dec_ready) begin
          m_valid = '0;
        end
        if (was_wait && serial_done) m_wait = 0;
      end
      #1;
      total++; if (dec_valid !== m_valid) begin bad++; $display("FAIL rnd_valid c=%0d: got %b exp %b", c, dec_valid, m_valid); end
      for (int k = 0; k < 4; k++) begin
        if (m_valid[k]) begin
          total++;
          if (dec_inst[k] !== m_inst[k] || dec_pc[k] !== m_pc[k] || dec_pred[k] !== m_pred[k]) begin
            bad++; $display("FAIL rnd_slot%0d c=%0d: got %h/%h/%b exp %h/%h/%b", k, c,
                            dec_inst[k], dec_pc[k], dec_pred[k], m_inst[k], m_pc[k], m_pred[k]);
          end
        end
      end
    end
`ifdef IB_ISSUE_PERF_EN
    total++; if (perf_issued !== m_issued) begin bad++; $display("FAIL perf_issued: got %0d exp %0d", perf_issued, m_issued); end
    total++; if (perf_empty_stall !== m_empty) begin bad++; $display("FAIL perf_empty: got %0d exp %0d", perf_empty_stall, m_empty); end
    total++; if (perf_serial_stall !== m_serial) begin bad++; $display("FAIL perf_serial: got %0d exp %0d", perf_serial_stall, m_serial); end
`endif
    clr = 1'b0; serial_done = 1'b0; inst_count = 5'd0;
  endtask

  initial begin
    test_reset();
    test_full_issue();
    test_partial_drain();
    test_serial();
    test_hold();
    test_flush();
    test_async_reset();
    test_random(3000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ib_issue_stage.md
Name: ib_issue_stage

Overview:
- Read-side controller for the instruction buffer.
- Each cycle it decides how many valid buffer entries to pop (up to ISSUE_WIDTH) and drives the buffer's thermometer read enable.
- Popped instructions are registered into a valid/ready decode packet.
- Serializing instructions (SYSTEM, MISC-MEM) issue alone, and issue stalls until the back-end reports completion.

Parameters:
- DATA_WIDTH, 32, instruction width
- ADDR_WIDTH, 32, PC width
- Depth, 32, buffer depth; sets the inst_count width to $clog2(Depth)
- Fetch_NUM, 4, number of buffer read slots presented
- ISSUE_WIDTH, 4, max instructions per packet; must satisfy 1 <= ISSUE_WIDTH <= Fetch_NUM

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  pipeline flush (same signal the buffer sees)
- inst_count  in  $clog2(Depth)  occupied buffer entries
- buf_inst_i  in  DATA_WIDTH x Fetch_NUM  buffer heads; slot 0 is the oldest
- buf_pc_i  in  ADDR_WIDTH x Fetch_NUM  PCs of the heads
- buf_pred_i  in  Fetch_NUM  predicted-taken bits of the heads
- inst_ren  out  4  buffer pop mask, thermometer from bit 0
- dec_valid  out  ISSUE_WIDTH  per-slot valid of the registered packet
- dec_inst  out  DATA_WIDTH x ISSUE_WIDTH  registered instructions
- dec_pc  out  ADDR_WIDTH x ISSUE_WIDTH  registered PCs
- dec_pred  out  ISSUE_WIDTH  registered prediction bits
- dec_ready  in  1  decode accepts the packet this cycle
- serial_done  in  1  one-cycle pulse: the serializing instruction has retired

Behaviour:
- Reset (async, rst_n=0):
  - dec_valid=0; dec_inst/dec_pc/dec_pred=0.
  - FSM=RUN; inst_ren=0 while reset is held.
- Packet state: pkt_busy = |dec_valid. Load enable ld = ~clr & (state==RUN) & (~pkt_busy | dec_ready).
- Issue count n (combinational):
  - avail = min(inst_count, ISSUE_WIDTH).
  - serial(k) = opcode[6:0] of slot k is 7'b1110011 or 7'b0001111.
  - If avail>0 and serial(0): n=1.
  - Otherwise n = min(avail, index of the first k<avail with serial(k)), or avail if there is no such k.
- Read enable:
  - inst_ren = ld ? ((1<<n)-1) : 0. It is combinational and valid in the same cycle the buffer samples it.
  - Bits at or above ISSUE_WIDTH are always 0.
- Packet register, on the clock edge where ld=1:
  - dec_valid[k] <= (k<n).
  - Slot data for k<n loaded from the buffer heads.
  - Slots k>=n: data don't-care, valid 0.
- Hold and drain:
  - pkt_busy & ~dec_ready & ~clr: packet held unchanged, inst_ren=0.
  - ld=1 with n=0: the packet drains to empty (dec_valid <= 0).
- FSM:
  - RUN -> WAIT_SERIAL on a load edge where serial(0) and n=1.
  - WAIT_SERIAL: inst_ren=0; the serializing packet still hands off via dec_ready normally.
  - WAIT_SERIAL -> RUN on serial_done.
  - serial_done in RUN is ignored.
- Flush: clr=1 forces inst_ren=0, dec_valid <= 0 and FSM <= RUN on that edge. It overrides dec_ready, serial_done and ld.
- Simultaneous events:
  - dec_ready and a new load in the same cycle give back-to-back packets with no bubble.
  - serial_done and clr in the same cycle resolve to RUN with an empty packet.
- Boundaries:
  - inst_count=0 gives n=0.
  - inst_count >= ISSUE_WIDTH caps n at ISSUE_WIDTH.
  - Wrap-around is handled entirely inside the buffer; this block sees only heads 0..Fetch_NUM-1.
- Reset mid-operation: asserting rst_n mid-WAIT_SERIAL or mid-packet returns immediately to the reset state; no pop is issued.

Optional Feature:
- Macro: IB_ISSUE_PERF_EN.
- When defined, add outputs:
  - perf_issued (32 bits): adds n on every load edge.
  - perf_empty_stall (32 bits): increments each cycle with state==RUN, ~pkt_busy and inst_count==0.
  - perf_serial_stall (32 bits): increments each cycle in WAIT_SERIAL.
- All three counters are cleared by reset only (not by clr) and wrap modulo 2^32.
- When undefined: no such ports and no counter logic.

Decomposition:
- Package ib_issue_pkg holds:
  - FSM state enum {RUN, WAIT_SERIAL}.
  - OPC_SYSTEM = 7'b1110011 and OPC_MISC_MEM = 7'b0001111.
  - A function is_serial(inst).
- One natural sub-module: ib_issue_count, the combinational n/inst_ren generator from inst_count and slot opcodes.

Test Plan:
- inst_count=6, four ADDI heads, dec_ready=1 -> inst_ren=4'b1111, next cycle dec_valid=4'b1111 with PCs 0x80000000..0x8000000C.
- inst_count=2, dec_ready=1 -> inst_ren=4'b0011, dec_valid=4'b0011; inst_count=0 -> inst_ren=0 and the packet drains to 0.
- Heads ADDI, ADDI, CSRRW, ADDI with count 4:
  - First cycle: inst_ren=4'b0011.
  - Next cycle, with CSRRW at head: inst_ren=4'b0001 and FSM=WAIT_SERIAL.
  - inst_ren stays 0 for 5 cycles until the serial_done pulse, then RUN resumes.
- Packet valid with dec_ready=0 for 3 cycles -> inst_ren=0 and outputs stable; dec_ready=1 -> accepted and reloaded the same cycle.
- clr during WAIT_SERIAL with a busy packet -> next cycle dec_valid=0, FSM=RUN, inst_ren=0 during the clr cycle.
- rst_n pulsed low mid-packet (asynchronous, between edges) -> dec_valid=0 immediately; with IB_ISSUE_PERF_EN, all counters read 0.
